key_event_capture: RTL
======================

KEY_EVENT_CAPTURE -- requirements
Module: key_event_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the consecutive stable samples needed to accept a new input level.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, SHALL set the event FIFO depth.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 address  in  2  Avalon-MM slave word address.
REQ-006 read  in  1  Avalon read strobe.
REQ-007 readdata  out  32  Avalon read data, registered.
REQ-008 write  in  1  Avalon write strobe.
REQ-009 writedata  in  32  Avalon write data.
REQ-010 key  in  2  raw pushbuttons, active-low, asynchronous.
REQ-011 switch  in  4  raw slide switches, asynchronous.
REQ-012 irq  out  1  interrupt, registered, level-high.

Function
REQ-013 key and switch SHALL each pass through a 2-flop synchronizer before debouncing.
REQ-014 Each debouncer SHALL update its stable output only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any mismatch SHALL restart its counter.
REQ-015 A press event SHALL be a debounced key 1->0 transition; the event code SHALL be {switch_db[3:0], 2'b00, press[1:0]}, press one-hot per key.
REQ-016 Presses of both keys accepted in the same cycle SHALL produce one entry with press = 2'b11.
REQ-017 An event SHALL be written into the FIFO the cycle after the debounced transition.
REQ-018 Push while full SHALL drop the event and set sticky overflow; the FIFO contents SHALL be unchanged.
REQ-019 Read of address 0 SHALL return {valid, 23'b0, code} one cycle later and pop on a non-empty FIFO; on an empty FIFO it SHALL return 0 and not pop.
REQ-020 Simultaneous push and pop when full SHALL both succeed; count SHALL stay unchanged.
REQ-021 Simultaneous push and pop when empty SHALL return empty data (no bypass); the push SHALL succeed.
REQ-022 Read of address 1 SHALL return status {count[7:0] at bits 15:8, irq_en bit 3, overflow bit 2, full bit 1, empty bit 0}, other bits 0.
REQ-023 Write to address 2 SHALL act as control: bit0 sets irq_en (level); bit1=1 flushes the FIFO; bit2=1 clears overflow. Flush SHALL take priority over a same-cycle push.
REQ-024 Read of address 3 SHALL return {26'b0, switch_db[3:0], key_db[1:0]}.
REQ-025 Reads of undecoded bits and writes to addresses 0, 1 and 3 SHALL have no effect.
REQ-026 irq SHALL be registered irq_en & ~empty.

Reset
REQ-027 While reset_n=0: FIFO empty, pointers 0, overflow 0, irq_en 0, readdata 0, irq 0, debounce counters 0, key_db 2'b11, switch_db 4'b0000.
REQ-028 Reset asserted mid-debounce or mid-read SHALL discard the pending event and read data.
REQ-029 Any input difference seen after reset release SHALL require a full DEBOUNCE_CYCLES period to be accepted.

Configuration
REQ-030 With KEY_EVENT_RELEASE_EN defined, a debounced 0->1 key transition SHALL also push an event, with code bit 2 = 1 and press[1:0] marking the released key(s).
REQ-031 Without KEY_EVENT_RELEASE_EN, releases SHALL push nothing, and code bit 2 SHALL always be 0.

Structure
REQ-032 Package key_event_pkg SHALL hold the address constants, status bit positions, code field positions and the event-code typedef.
REQ-033 Sub-module key_debouncer (synchronizer plus counter, one bit wide) SHALL be instantiated once per key bit and once per switch bit.

Verification (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-034 switch=4'hA, key[0] low for 10 cycles, then read addr 0 -> readdata=32'h8000_00A1, status empty=1.
REQ-035 key[1] glitch low for 3 cycles -> no event; addr 1 reads count=0, empty=1.
REQ-036 Five key[0] presses, no reads -> count=4, full=1, overflow=1; write addr 2 with 32'h4 -> overflow=0.
REQ-037 Write 32'h1 to addr 2, then one press -> irq=1; pop that event -> irq=0 on the next cycle.
REQ-038 Four entries queued, push and pop in the same cycle -> count stays 4 and the oldest code is returned.
REQ-039 reset_n pulsed low during a 2-cycle-stable press -> no event after release; all outputs at reset values.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared constants for the key event capture block: register map, status and
// control bit positions, and the packed layout of a captured event code.
package key_event_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_INPUT  = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_IRQ_EN    = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVF_CLR = 2;

  localparam int CODE_PRESS_LSB = 0;
  localparam int CODE_REL_BIT   = 2;
  localparam int CODE_SW_LSB    = 4;
  localparam int RD_VALID_BIT   = 31;

  typedef struct packed {
    logic [3:0] sw;
    logic       rsvd;
    logic       rel;
    logic [1:0] press;
  } event_code_t;

  function automatic event_code_t make_code(input logic [3:0] sw,
                                            input logic       rel,
                                            input logic [1:0] press);
    event_code_t c;
    c.sw    = sw;
    c.rsvd  = 1'b0;
    c.rel   = rel;
    c.press = press;
    return c;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One-bit 2-flop synchronizer followed by a run-length debouncer; the stable
// output only follows after DEBOUNCE_CYCLES consecutive differing samples.
module key_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronizer flops start at the reset level so release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      db_q    <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // For a single bit, "differs from stable" is the same as "same new level".
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else                                    cnt_d = cnt_q + CW'(1);
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/key_event_capture.sv
// Debounced pushbutton/switch capture with an event FIFO behind an Avalon-MM
// slave. Define KEY_EVENT_RELEASE_EN to also queue key-release events.
module key_event_capture
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [1:0]  key,
  input  logic [3:0]  switch,
  output logic        irq
);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [1:0] key_db;
  logic [3:0] sw_db;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db (
      .clk(clk), .reset_n(reset_n), .din(key[i]), .dout(key_db[i]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_sw
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
      .clk(clk), .reset_n(reset_n), .din(switch[i]), .dout(sw_db[i]));
  end

  logic [1:0]  key_prev_q;
  logic [1:0]  press;
  logic        evt_vld;
  event_code_t evt_code;

  always_comb begin
    press = key_prev_q & ~key_db;
`ifdef KEY_EVENT_RELEASE_EN
    evt_vld  = (|press) | (|(~key_prev_q & key_db));
    evt_code = (|press) ? make_code(sw_db, 1'b0, press)
                        : make_code(sw_db, 1'b1, ~key_prev_q & key_db);
`else
    evt_vld  = |press;
    evt_code = make_code(sw_db, 1'b0, press);
`endif
  end

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q;
  logic [31:0]     readdata_q, readdata_d, status;
  event_code_t     mem_q [FIFO_DEPTH];
  logic            empty, full, ctrl_wr, flush, pop, push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNTW'(FIFO_DEPTH));
  assign ctrl_wr = write && (address == ADDR_CTRL);
  assign flush   = ctrl_wr && writedata[CTRL_FLUSH];
  assign pop     = read && (address == ADDR_DATA) && !empty;
  // A full FIFO still accepts a push when the same cycle pops; flush wins over both.
  assign push    = evt_vld && !flush && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      irq_en_d = writedata[CTRL_IRQ_EN];
      if (writedata[CTRL_OVF_CLR]) ovf_d = 1'b0;
    end
    if (evt_vld && full && !pop && !flush) ovf_d = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_comb begin
    status               = '0;
    status[ST_EMPTY]     = empty;
    status[ST_FULL]      = full;
    status[ST_OVF]       = ovf_q;
    status[ST_IRQ_EN]    = irq_en_q;
    status[ST_COUNT_LSB +: 8] = 8'(count_q);
  end

  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        ADDR_DATA:   readdata_d = pop ? {1'b1, 23'b0, mem_q[rd_ptr_q]} : 32'b0;
        ADDR_STATUS: readdata_d = status;
        ADDR_INPUT:  readdata_d = {26'b0, sw_db, key_db};
        default:     readdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_prev_q <= 2'b11;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      key_prev_q <= key_db;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_q & ~empty;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= evt_code;
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata[31:3]};

endmodule
